alu_arbiter: RTL and testbench

//  Shares one combinational alu (a, b, ALUControl -> result, zero) between two requesters.

---
 rtl/alu_arbiter.sv | 177 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between two requesters. Round-robin
//            arbitration with valid/ready handshakes. Each accepted operation is
//            latched onto the ALU inputs for one cycle. The ALU result/zero is
//            then registered and returned on a tagged response channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset              clock (posedge), asynchronous active-high reset
//   reqN_valid / reqN_ready request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b          operands  (DATA_W)
//   reqN_ctrl               ALUControl (CTRL_W)
//   alu_a, alu_b, alu_ctrl  registered drive to the external ALU
//   alu_result, alu_zero    combinational return from the external ALU
//   rsp_valid / rsp_ready   response handshake
//   rsp_id                  requester owning the response
//   rsp_result, rsp_zero    registered ALU outputs
//   gnt_cnt0, gnt_cnt1      saturating per-requester accept counters
//                           (present only with ALU_ARB_STATS_EN defined)
// Configuration macro: ALU_ARB_STATS_EN
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic [CTRL_W-1:0]   alu_ctrl_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_zero_q;

    logic                gnt_vld;
    logic                gnt_id;

    // Grant decision. Readys are held low while reset is asserted so that all
    // outputs read zero during reset, even with valid requests present.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!reset && state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = ~last_grant_q;
            end else if (req0_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (req1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_vld && !gnt_id;
    assign req1_ready = gnt_vld &&  gnt_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        alu_a_q      <= gnt_id ? req1_a    : req0_a;
                        alu_b_q      <= gnt_id ? req1_b    : req0_b;
                        alu_ctrl_q   <= gnt_id ? req1_ctrl : req0_ctrl;
                        last_grant_q <= gnt_id;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // last_grant_q always holds the owner of the in-flight op.
                    rsp_result_q <= alu_result;
                    rsp_zero_q   <= alu_zero;
                    rsp_id_q     <= last_grant_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating accept counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && cnt0_q != {CNT_W{1'b1}}) begin
                cnt0_q <= cnt0_q + c_cnt_one;
            end
            if (req1_ready && cnt1_q != {CNT_W{1'b1}}) begin
                cnt1_q <= cnt1_q + c_cnt_one;
            end
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`else
    localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Directed scenarios plus
//            randomized traffic, compared against a transaction-level model.
//            Honours ALU_ARB_STATS_EN for the grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DATA_W    = 64;
    localparam int CTRL_W    = 4;
    localparam int TB_CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result, rsp_result;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero;
`ifdef ALU_ARB_STATS_EN
    logic [TB_CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Reference ALU (MIPS-style ALUControl encodings).
    function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [CTRL_W-1:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_zero   = (alu_result == '0);

    alu_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
        ,
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One operation may be outstanding. A response becomes visible two
    // cycles after its accept cycle and stays until taken. The next accept
    // is possible only in the cycle after the response is taken.
    bit              m_pend;
    int              m_age;
    bit              m_last;
    bit              m_exp_id;
    logic [63:0]     m_exp_res;
    bit              m_exp_zero;
    logic [63:0]     m_last_res;
    bit              m_last_zero;
    logic [63:0]     m_alu_a, m_alu_b;
    logic [3:0]      m_alu_ctrl;
    int              m_cnt[2];
    int              m_accepts[$];

    task automatic model_reset();
        m_pend = 0; m_age = 0; m_last = 1'b1;
        m_last_res = '0; m_last_zero = 1'b0;
        m_alu_a = '0; m_alu_b = '0; m_alu_ctrl = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    // Called at the negedge of each cycle after inputs are stable.
    task automatic model_check();
        bit exp_v, busy, done;
        int w;
        busy = m_pend;
        if (m_pend) m_age++;
        exp_v = m_pend && (m_age >= 2);
        check("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
            check("rsp_id", rsp_id, m_exp_id);
            check("rsp_result", rsp_result, m_exp_res);
            check("rsp_zero", rsp_zero, m_exp_zero);
            m_last_res  = m_exp_res;
            m_last_zero = m_exp_zero;
        end else begin
            check("rsp_result_hold", rsp_result, m_last_res);
            check("rsp_zero_hold", rsp_zero, m_last_zero);
        end
        check("alu_a", alu_a, m_alu_a);
        check("alu_b", alu_b, m_alu_b);
        check("alu_ctrl", alu_ctrl, m_alu_ctrl);
`ifdef ALU_ARB_STATS_EN
        check("gnt_cnt0", gnt_cnt0, (m_cnt[0] > 3) ? 3 : m_cnt[0]);
        check("gnt_cnt1", gnt_cnt1, (m_cnt[1] > 3) ? 3 : m_cnt[1]);
`endif
        done = exp_v && rsp_ready;
        if (done) m_pend = 0;
        w = -1;
        if (!busy) begin
            if (req0_valid && req1_valid) w = m_last ? 0 : 1;
            else if (req0_valid)          w = 0;
            else if (req1_valid)          w = 1;
        end
        check("req0_ready", req0_ready, w == 0);
        check("req1_ready", req1_ready, w == 1);
        if (w >= 0) begin
            m_pend = 1; m_age = 0; m_last = (w == 1);
            m_exp_id = (w == 1);
            m_alu_a    = (w == 1) ? req1_a : req0_a;
            m_alu_b    = (w == 1) ? req1_b : req0_b;
            m_alu_ctrl = (w == 1) ? req1_ctrl : req0_ctrl;
            m_exp_res  = alu_fn(m_alu_a, m_alu_b, m_alu_ctrl);
            m_exp_zero = (m_exp_res == 0);
            m_cnt[w]++;
            m_accepts.push_back(w);
        end
    endtask

    // Drive one cycle of inputs (just after posedge), check at negedge.
    task automatic step(input bit v0, input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] c0,
                        input bit v1, input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] c1,
                        input bit rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
        rsp_ready  = rr;
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready0"}, req0_ready, 0);
        check({tag, "_ready1"}, req1_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_zero"}, rsp_zero, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_ctrl"}, alu_ctrl, 0);
`ifdef ALU_ARB_STATS_EN
        check({tag, "_cnt0"}, gnt_cnt0, 0);
        check({tag, "_cnt1"}, gnt_cnt1, 0);
`endif
    endtask

    logic [3:0] ctrl_tbl [7];

    initial begin
        ctrl_tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;   // readys must still read 0 in reset
        req0_a = 64'd3; req0_b = 64'd4; req0_ctrl = 4'b0010;
        req1_a = 64'd3; req1_b = 64'd4; req1_ctrl = 4'b0010;
        rsp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: req0 add 5+7
        step(1, 64'd5, 64'd7, 4'b0010, 0, 0, 0, 0, 1);
        idle_steps(2, 1);
        check("t1_result", rsp_result, 64'd12);
        check("t1_zero", rsp_zero, 0);

        // 2: req1 sub 9-9
        step(0, 0, 0, 0, 1, 64'd9, 64'd9, 4'b0110, 1);
        idle_steps(2, 1);
        check("t2_result", rsp_result, 64'd0);
        check("t2_zero", rsp_zero, 1);

        // 3: both valid continuously from reset -> 0,1,0,1
        reset = 1'b1; #1; reset = 1'b0;
        model_reset();
        m_accepts.delete();
        for (int i = 0; i < 12; i++)
            step(1, 64'(i), 64'd2, 4'b0010, 1, 64'(i), 64'd1, 4'b0110, 1);
        check("t3_accepts", m_accepts.size(), 4);
        for (int i = 0; i < m_accepts.size(); i++)
            check("t3_order", m_accepts[i], i % 2);

        // 4: backpressure with req1 waiting
        idle_steps(3, 1);
        step(1, 64'h10, 64'h20, 4'b0001, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 0, 1, 64'h7, 64'h7, 4'b0110, 0);
        step(0, 0, 0, 0, 1, 64'h7, 64'h7, 4'b0110, 1);
        step(0, 0, 0, 0, 1, 64'h7, 64'h7, 4'b0110, 1);
        idle_steps(3, 1);

        // 5: reset during ISSUE discards the op; req0 then wins the tie
        step(0, 0, 0, 0, 1, 64'h55, 64'h22, 4'b0010, 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #2 reset = 1'b1;
        #1 check_all_zero("t5_reset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 64'h1, 64'h1, 4'b0110, 1, 64'h2, 64'h3, 4'b0010, 1);
        idle_steps(3, 1);

        // 6: counters saturate (checked by model when stats are compiled in)
        for (int i = 0; i < 5; i++) begin
            step(1, 64'(i), 64'd1, 4'b0010, 0, 0, 0, 0, 1);
            idle_steps(2, 1);
        end

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [63:0] a0, b0, a1, b1;
            a0 = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            b0 = ($urandom_range(0, 3) == 0) ? a0 : {$urandom, $urandom};
            a1 = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            b1 = ($urandom_range(0, 3) == 0) ? a1 : {$urandom, $urandom};
            step($urandom_range(0, 2) != 0, a0, b0, ctrl_tbl[$urandom_range(0, 6)],
                 $urandom_range(0, 2) != 0, a1, b1, ctrl_tbl[$urandom_range(0, 6)],
                 $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
